// File: rtl/bus_drive_decoder.sv
// bus_drive_decoder: sequential 5-to-32 bus-source enable decoder.
// A binary source code is accepted through a valid/ready handshake. The
// matching one-hot enable is then driven for in_hold+1 cycles. Afterwards,
// GAP_CYCLES dead cycles keep all enables low (break-before-make).
// Optional feature macro: BUS_DRIVE_DECODER_ERR_EN. When it is defined, the
// block gains a sticky err output, and an illegal code skips the drive phase.
module bus_drive_decoder #(
  parameter int NUM_OUT    = 32,
  parameter int HOLD_W     = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [4:0]         in_code,
  input  logic [HOLD_W-1:0]  in_hold,
  output logic               in_ready,
  output logic [NUM_OUT-1:0] out_sel,
  output logic               out_active,
  output logic               done
`ifdef BUS_DRIVE_DECODER_ERR_EN
  ,
  output logic               err
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? 2'(GAP_CYCLES - 1) : 2'd0;
  localparam state_t     POST_DRIVE = (GAP_CYCLES > 0) ? GAP : IDLE;

  state_t              state;
  state_t              state_n;
  logic [4:0]          code_q;
  logic [4:0]          code_n;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [1:0]          gap_cnt;
  logic                accept;
  logic                skip;
  logic [NUM_OUT-1:0]  sel_n;
  logic                active_n;
  logic                done_n;

  assign in_ready = (state == IDLE) && !clear;
  assign accept   = in_valid && in_ready;

`ifdef BUS_DRIVE_DECODER_ERR_EN
  logic illegal;
  assign illegal = ({27'd0, in_code} >= 32'(NUM_OUT));
  assign skip    = accept && illegal;
`else
  assign skip    = 1'b0;
`endif

  // State register, counters and registered outputs
  always_ff @(posedge clock) begin
    if (clear) begin
      state      <= IDLE;
      code_q     <= '0;
      hold_cnt   <= '0;
      gap_cnt    <= '0;
      out_sel    <= '0;
      out_active <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      out_sel    <= sel_n;
      out_active <= active_n;
      done       <= done_n;
      if (accept) begin
        code_q   <= in_code;
        hold_cnt <= in_hold;
      end else if (state == DRIVE && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
      if (state_n == GAP && state != GAP) begin
        gap_cnt <= GAP_LOAD;
      end else if (state == GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

`ifdef BUS_DRIVE_DECODER_ERR_EN
  // Sticky illegal-code flag, cleared only by clear
  always_ff @(posedge clock) begin
    if (clear) begin
      err <= 1'b0;
    end else if (skip) begin
      err <= 1'b1;
    end
  end
`endif

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = skip ? POST_DRIVE : DRIVE;
        end
      end
      DRIVE: begin
        if (hold_cnt == '0) begin
          state_n = POST_DRIVE;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Next output values; they are registered, so they are decoded from next state
  always_comb begin
    code_n   = accept ? in_code : code_q;
    sel_n    = '0;
    active_n = (state_n == DRIVE);
    done_n   = ((state == DRIVE) && (hold_cnt == '0)) || skip;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      if (state_n == DRIVE && code_n == 5'(i)) begin
        sel_n[i] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_drive_decoder.sv
// Directed self-checking bench for bus_drive_decoder.
// u32: default configuration (32 outputs, one gap cycle).
// u16: 16 outputs with no gap cycle, for illegal-code and back-to-back cases.
module tb_bus_drive_decoder;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        v32 = 1'b0;
  logic        v16 = 1'b0;
  logic [4:0]  code = '0;
  logic [3:0]  hold = '0;

  logic        r32, act32, done32;
  logic [31:0] sel32;
  logic        r16, act16, done16;
  logic [15:0] sel16;
`ifdef BUS_DRIVE_DECODER_ERR_EN
  logic        err32, err16;
`endif

  int vectors = 0;
  int errors  = 0;
  logic        mon_en = 1'b0;
  logic [31:0] prev32 = '0;
  logic [15:0] prev16 = '0;

  always #5 clock = ~clock;

  bus_drive_decoder u32 (
    .clock(clock), .clear(clear), .in_valid(v32), .in_code(code), .in_hold(hold),
    .in_ready(r32), .out_sel(sel32), .out_active(act32), .done(done32)
`ifdef BUS_DRIVE_DECODER_ERR_EN
    , .err(err32)
`endif
  );

  bus_drive_decoder #(.NUM_OUT(16), .HOLD_W(4), .GAP_CYCLES(0)) u16 (
    .clock(clock), .clear(clear), .in_valid(v16), .in_code(code), .in_hold(hold),
    .in_ready(r16), .out_sel(sel16), .out_active(act16), .done(done16)
`ifdef BUS_DRIVE_DECODER_ERR_EN
    , .err(err16)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bus-safety monitor: at most one enable, no direct nonzero-to-nonzero change
  always @(negedge clock) begin
    if (mon_en && !clear) begin
      vectors++;
      assert ($countones(sel32) <= 1 && $countones(sel16) <= 1) else begin
        errors++;
        $error("FAIL onehot observed=%h/%h expected=popcount<=1", sel32, sel16);
      end
      vectors++;
      assert (!((prev32 != 0 && sel32 != 0 && sel32 != prev32) ||
                (prev16 != 0 && sel16 != 0 && sel16 != prev16))) else begin
        errors++;
        $error("FAIL bbm observed=%h->%h expected=zero cycle between sources", prev32, sel32);
      end
    end
    prev32 = sel32;
    prev16 = sel16;
  end

  initial begin
    // Reset
    tick(); tick();
    chk("rst_sel", sel32, 32'h0);
    chk("rst_act", {31'd0, act32}, 32'd0);
    chk("rst_done", {31'd0, done32}, 32'd0);
    chk("rst_ready_in_clear", {31'd0, r32}, 32'd0);
    clear = 1'b0;
    #1;
    chk("rst_ready", {31'd0, r32}, 32'd1);
    mon_en = 1'b1;

    // code 0, hold 0
    v32 = 1'b1; code = 5'd0; hold = 4'd0;
    tick(); v32 = 1'b0;
    chk("c0_sel", sel32, 32'h00000001);
    chk("c0_act", {31'd0, act32}, 32'd1);
    chk("c0_ready", {31'd0, r32}, 32'd0);
    chk("c0_nodone", {31'd0, done32}, 32'd0);
    tick();
    chk("c0_sel_off", sel32, 32'h0);
    chk("c0_done", {31'd0, done32}, 32'd1);
    chk("c0_gap_ready", {31'd0, r32}, 32'd0);
    tick();
    chk("c0_done_once", {31'd0, done32}, 32'd0);
    chk("c0_ready_back", {31'd0, r32}, 32'd1);

    // code 31, hold 3 -> four drive cycles
    v32 = 1'b1; code = 5'd31; hold = 4'd3;
    tick(); v32 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("c31_sel", sel32, 32'h80000000);
      chk("c31_act", {31'd0, act32}, 32'd1);
      chk("c31_nodone", {31'd0, done32}, 32'd0);
      tick();
    end
    chk("c31_done", {31'd0, done32}, 32'd1);
    chk("c31_sel_off", sel32, 32'h0);
    tick();
    chk("c31_done_once", {31'd0, done32}, 32'd0);
    chk("c31_ready", {31'd0, r32}, 32'd1);

    // Back-to-back 5 then 6 with in_valid held high
    v32 = 1'b1; code = 5'd5; hold = 4'd0;
    tick(); code = 5'd6;
    chk("b2b_sel5", sel32, 32'h20);
    tick();
    chk("b2b_gap0", sel32, 32'h0);
    chk("b2b_done5", {31'd0, done32}, 32'd1);
    tick();
    chk("b2b_idle", sel32, 32'h0);
    chk("b2b_ready", {31'd0, r32}, 32'd1);
    tick(); v32 = 1'b0;
    chk("b2b_sel6", sel32, 32'h40);
    tick();
    chk("b2b_done6", {31'd0, done32}, 32'd1);
    tick();

    // clear during DRIVE of code 10, hold 7
    v32 = 1'b1; code = 5'd10; hold = 4'd7;
    tick(); v32 = 1'b0;
    chk("clr_sel", sel32, 32'h400);
    tick();
    clear = 1'b1;
    tick();
    chk("clr_sel_off", sel32, 32'h0);
    chk("clr_act_off", {31'd0, act32}, 32'd0);
    chk("clr_nodone", {31'd0, done32}, 32'd0);
    clear = 1'b0;
    #1;
    chk("clr_ready", {31'd0, r32}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("clr_no_late_done", {31'd0, done32}, 32'd0);
    end

    // Illegal code on the 16-output instance (no gap)
    v16 = 1'b1; code = 5'd20; hold = 4'd2;
    tick(); v16 = 1'b0;
`ifdef BUS_DRIVE_DECODER_ERR_EN
    chk("ill_done_early", {31'd0, done16}, 32'd1);
    chk("ill_err", {31'd0, err16}, 32'd1);
    chk("ill_act_skip", {31'd0, act16}, 32'd0);
    chk("ill_sel", {16'd0, sel16}, 32'h0);
    chk("ill_ready", {31'd0, r16}, 32'd1);
    tick();
    chk("ill_done_once", {31'd0, done16}, 32'd0);
    chk("ill_err_sticky", {31'd0, err16}, 32'd1);
    chk("ill_err_other", {31'd0, err32}, 32'd0);
`else
    for (int k = 0; k < 3; k++) begin
      chk("ill_sel", {16'd0, sel16}, 32'h0);
      chk("ill_act", {31'd0, act16}, 32'd1);
      chk("ill_nodone", {31'd0, done16}, 32'd0);
      tick();
    end
    chk("ill_done", {31'd0, done16}, 32'd1);
    chk("ill_ready_nogap", {31'd0, r16}, 32'd1);
    chk("ill_act_off", {31'd0, act16}, 32'd0);
    tick();
`endif

    // Back-to-back on the no-gap instance: accept in the done cycle
    v16 = 1'b1; code = 5'd3; hold = 4'd0;
    tick();
    chk("ng_sel_a", {16'd0, sel16}, 32'h8);
    tick();
    chk("ng_done_a", {31'd0, done16}, 32'd1);
    chk("ng_ready_a", {31'd0, r16}, 32'd1);
    chk("ng_zero_a", {16'd0, sel16}, 32'h0);
    tick(); v16 = 1'b0;
    chk("ng_sel_b", {16'd0, sel16}, 32'h8);
    tick();
    chk("ng_done_b", {31'd0, done16}, 32'd1);
    tick();

`ifdef BUS_DRIVE_DECODER_ERR_EN
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("err_cleared", {31'd0, err16}, 32'd0);
`endif

    // hold all-ones -> 16 drive cycles
    v32 = 1'b1; code = 5'd3; hold = 4'hF;
    tick(); v32 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("h15_sel", sel32, 32'h8);
      chk("h15_nodone", {31'd0, done32}, 32'd0);
      tick();
    end
    chk("h15_done", {31'd0, done32}, 32'd1);
    chk("h15_sel_off", sel32, 32'h0);
    tick();
    chk("h15_ready", {31'd0, r32}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
